// File: rtl/arith_sched.sv
// arith_sched: round-robin two-port sequencer for the 16-bit arithmetic unit.
// Wide ADD/SUB run as two chained 16-bit passes; results return on one tagged channel.
package CPU_package;
    parameter int unsigned DATA_WIDTH = 16;

    typedef enum logic [3:0] {
        ALU_OP_ADD = 4'd0,
        ALU_OP_SUB = 4'd1,
        ALU_OP_INC = 4'd2,
        ALU_OP_DEC = 4'd3,
        ALU_OP_MUL = 4'd4,
        ALU_OP_DIV = 4'd5,
        ALU_OP_AND = 4'd6,
        ALU_OP_OR  = 4'd7,
        ALU_OP_XOR = 4'd8
    } enum_alu_opcode_t;
endpackage

module arith_sched #(
    parameter int unsigned DATA_WIDTH = CPU_package::DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req0_valid,
    output logic                            req0_ready,
    input  CPU_package::enum_alu_opcode_t   req0_op,
    input  logic [2*DATA_WIDTH-1:0]         req0_a,
    input  logic [2*DATA_WIDTH-1:0]         req0_b,
    input  logic                            req0_cin,
    input  logic                            req0_wide,
    input  logic                            req1_valid,
    output logic                            req1_ready,
    input  CPU_package::enum_alu_opcode_t   req1_op,
    input  logic [2*DATA_WIDTH-1:0]         req1_a,
    input  logic [2*DATA_WIDTH-1:0]         req1_b,
    input  logic                            req1_cin,
    input  logic                            req1_wide,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_id,
    output logic [2*DATA_WIDTH-1:0]         rsp_data,
    output logic                            rsp_carry,
    output logic                            rsp_err,
    output logic [DATA_WIDTH-1:0]           alu_a,
    output logic [DATA_WIDTH-1:0]           alu_b,
    output logic                            alu_cin,
    output CPU_package::enum_alu_opcode_t   alu_op,
    input  logic [DATA_WIDTH-1:0]           alu_res,
    input  logic [1:0]                      alu_flag
);
    localparam int unsigned W = DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]     state_q, state_d;
    logic           last_q, last_d;
    logic           id_q, id_d;
    logic           wide_q, wide_d;
    logic [W-1:0]   a_hi_q, a_hi_d;
    logic [W-1:0]   b_hi_q, b_hi_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [2*W-1:0] rsp_data_q, rsp_data_d;
    logic           rsp_carry_q, rsp_carry_d;
    logic           rsp_err_q, rsp_err_d;
    logic [W-1:0]   alu_a_q, alu_a_d;
    logic [W-1:0]   alu_b_q, alu_b_d;
    logic           alu_cin_q, alu_cin_d;
    CPU_package::enum_alu_opcode_t alu_op_q, alu_op_d;

    logic                          grant_any, grant_id;
    CPU_package::enum_alu_opcode_t sel_op;
    logic [2*W-1:0]                sel_a, sel_b;
    logic                          sel_cin, sel_wide;
    logic                          op_addsub, div_zero;
    logic                          unused_flag;

    assign unused_flag = alu_flag[1];

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_id  = ~last_q;
        end else if (req0_valid) begin
            grant_any = 1'b1;
        end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign req0_ready = rst_n && (state_q == S_IDLE) && grant_any && !grant_id;
    assign req1_ready = rst_n && (state_q == S_IDLE) && grant_any &&  grant_id;

    always_comb begin
        sel_op   = grant_id ? req1_op   : req0_op;
        sel_a    = grant_id ? req1_a    : req0_a;
        sel_b    = grant_id ? req1_b    : req0_b;
        sel_cin  = grant_id ? req1_cin  : req0_cin;
        sel_wide = grant_id ? req1_wide : req0_wide;
    end

    // alu_op_q keeps the operation for both passes, alu_b_q the low divisor.
    assign op_addsub = (alu_op_q == CPU_package::ALU_OP_ADD) || (alu_op_q == CPU_package::ALU_OP_SUB);
    assign div_zero  = (alu_op_q == CPU_package::ALU_OP_DIV) && (alu_b_q == '0);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        wide_d      = wide_q;
        a_hi_d      = a_hi_q;
        b_hi_d      = b_hi_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_op_d    = alu_op_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    alu_a_d   = sel_a[W-1:0];
                    alu_b_d   = sel_b[W-1:0];
                    alu_cin_d = sel_cin;
                    alu_op_d  = sel_op;
                    a_hi_d    = sel_a[2*W-1:W];
                    b_hi_d    = sel_b[2*W-1:W];
                    wide_d    = sel_wide;
                    id_d      = grant_id;
                    last_d    = grant_id;
                    state_d   = S_LO;
                end
            end
            S_LO: begin
                if (div_zero) begin
                    rsp_data_d  = {{W{1'b0}}, {W{1'b1}}};
                    rsp_carry_d = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    rsp_data_d  = {{W{1'b0}}, alu_res};
                    rsp_carry_d = alu_flag[0];
                    rsp_err_d   = wide_q && !op_addsub;
                    if (wide_q && op_addsub) begin
                        alu_a_d   = a_hi_q;
                        alu_b_d   = b_hi_q;
                        alu_cin_d = alu_flag[0];
                        state_d   = S_HI;
                    end else begin
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_HI: begin
                rsp_data_d  = {alu_res, rsp_data_q[W-1:0]};
                rsp_carry_d = alu_flag[0];
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            default: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            wide_q      <= 1'b0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_op_q    <= CPU_package::ALU_OP_ADD;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            wide_q      <= wide_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_op_q    <= alu_op_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_err   = rsp_err_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign alu_op    = alu_op_q;

endmodule
